// File: rtl/key_event_if.sv
// Key-event link: PS/2 scan bytes and frame tick in, single-cycle game-control pulses out.
// All strobes are single-cycle and there is no backpressure: scan_valid/tick_game
// qualify their cycle only, and key_* pulses are never held or retried.
interface key_event_if;
   logic       tick_game;
   logic       scan_valid;
   logic [7:0] scan_code;
   logic       key_left;
   logic       key_right;
   logic       key_down;
   logic       key_rotate;
   logic       key_drop;
   logic [4:0] keys_held;

   modport master (
      input  tick_game, scan_valid, scan_code,
      output key_left, key_right, key_down, key_rotate, key_drop, keys_held
   );

   modport slave (
      output tick_game, scan_valid, scan_code,
      input  key_left, key_right, key_down, key_rotate, key_drop, keys_held
   );
endinterface

// File: rtl/key_event_encoder.sv
// PS/2 Set 2 scan-code decoder producing game-control key pulses with
// DAS/ARR auto-repeat for left/right and fixed-rate soft-drop repeat.
module key_event_encoder #(
   parameter int DAS_FRAMES  = 10,
   parameter int ARR_FRAMES  = 3,
   parameter int SOFT_FRAMES = 2,
   parameter int CNT_W       = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   key_event_if.master kev,
   output logic [1:0]  dbg_state_o
);

   typedef enum logic [1:0] {
      S_BASE    = 2'd0,
      S_EXT     = 2'd1,
      S_BRK     = 2'd2,
      S_EXT_BRK = 2'd3
   } dec_state_e;

   localparam int K_LEFT   = 0;
   localparam int K_RIGHT  = 1;
   localparam int K_DOWN   = 2;
   localparam int K_ROTATE = 3;
   localparam int K_DROP   = 4;

   localparam logic [7:0] B_EXT   = 8'hE0;
   localparam logic [7:0] B_BRK   = 8'hF0;
   localparam logic [7:0] B_DROP  = 8'h29;
   localparam logic [7:0] B_LEFT  = 8'h6B;
   localparam logic [7:0] B_RIGHT = 8'h74;
   localparam logic [7:0] B_DOWN  = 8'h72;
   localparam logic [7:0] B_ROT   = 8'h75;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] DAS_C   = CNT_W'(DAS_FRAMES);
   localparam logic [CNT_W-1:0] ARR_C   = CNT_W'(ARR_FRAMES);
   localparam logic [CNT_W-1:0] SOFT_C  = CNT_W'(SOFT_FRAMES);

   dec_state_e       state_q, state_d;
   logic [4:0]       held_q, held_d;
   logic [4:0]       pulse_q, pulse_d;
   logic             lr_sel_q, lr_sel_d;   // 0: left repeats, 1: right repeats
   logic             lr_arr_q, lr_arr_d;   // 0: DAS phase, 1: ARR phase
   logic [CNT_W-1:0] lr_cnt_q, lr_cnt_d;
   logic [CNT_W-1:0] dn_cnt_q, dn_cnt_d;

   logic [4:0]       make_v, brk_v, press_v;
   logic             act_held, oth_held, brk_act, lr_pulse, dn_pulse;
   logic [CNT_W-1:0] lr_inc, dn_inc;

   function automatic logic [4:0] ext_key(input logic [7:0] code);
      logic [4:0] k;
      k = '0;
      case (code)
         B_LEFT:  k[K_LEFT]   = 1'b1;
         B_RIGHT: k[K_RIGHT]  = 1'b1;
         B_DOWN:  k[K_DOWN]   = 1'b1;
         B_ROT:   k[K_ROTATE] = 1'b1;
         default: k = '0;
      endcase
      return k;
   endfunction

   always_comb begin
      state_d = state_q;
      make_v  = '0;
      brk_v   = '0;
      if (kev.scan_valid) begin
         unique case (state_q)
            S_BASE: begin
               if (kev.scan_code == B_EXT)       state_d = S_EXT;
               else if (kev.scan_code == B_BRK)  state_d = S_BRK;
               else if (kev.scan_code == B_DROP) make_v[K_DROP] = 1'b1;
            end
            S_EXT: begin
               if (kev.scan_code == B_BRK) state_d = S_EXT_BRK;
               else if (kev.scan_code != B_EXT) begin
                  make_v  = ext_key(kev.scan_code);
                  state_d = S_BASE;
               end
            end
            S_BRK: begin
               if (kev.scan_code == B_DROP) brk_v[K_DROP] = 1'b1;
               state_d = S_BASE;
            end
            S_EXT_BRK: begin
               brk_v   = ext_key(kev.scan_code);
               state_d = S_BASE;
            end
            default: state_d = S_BASE;
         endcase
      end
   end

   // Typematic re-makes of an already held key must not produce a press pulse.
   assign press_v = make_v & ~held_q;
   assign held_d  = (held_q & ~brk_v) | make_v;

   assign act_held = lr_sel_q ? held_q[K_RIGHT] : held_q[K_LEFT];
   assign oth_held = lr_sel_q ? held_q[K_LEFT]  : held_q[K_RIGHT];
   assign brk_act  = lr_sel_q ? brk_v[K_RIGHT]  : brk_v[K_LEFT];
   assign lr_inc   = (lr_cnt_q == CNT_MAX) ? lr_cnt_q : lr_cnt_q + 1'b1;
   assign dn_inc   = (dn_cnt_q == CNT_MAX) ? dn_cnt_q : dn_cnt_q + 1'b1;

   always_comb begin
      lr_sel_d = lr_sel_q;
      lr_arr_d = lr_arr_q;
      lr_cnt_d = lr_cnt_q;
      lr_pulse = 1'b0;
      if (press_v[K_LEFT] || press_v[K_RIGHT]) begin
         lr_sel_d = press_v[K_RIGHT];
         lr_arr_d = 1'b0;
         lr_cnt_d = '0;
      end else if (brk_act && act_held) begin
         // Releasing the repeating key hands repeat to the other one, if still held.
         lr_arr_d = 1'b0;
         lr_cnt_d = '0;
         if (oth_held) lr_sel_d = ~lr_sel_q;
      end else if (!act_held) begin
         lr_arr_d = 1'b0;
         lr_cnt_d = '0;
      end else if (kev.tick_game) begin
         if (!lr_arr_q && lr_inc == DAS_C) begin
            lr_pulse = 1'b1;
            lr_arr_d = 1'b1;
            lr_cnt_d = '0;
         end else if (lr_arr_q && lr_inc == ARR_C) begin
            lr_pulse = 1'b1;
            lr_cnt_d = '0;
         end else begin
            lr_cnt_d = lr_inc;
         end
      end
   end

   always_comb begin
      dn_cnt_d = dn_cnt_q;
      dn_pulse = 1'b0;
      if (!held_q[K_DOWN] || brk_v[K_DOWN]) begin
         dn_cnt_d = '0;
      end else if (kev.tick_game) begin
         if (dn_inc == SOFT_C) begin
            dn_pulse = 1'b1;
            dn_cnt_d = '0;
         end else begin
            dn_cnt_d = dn_inc;
         end
      end
   end

   always_comb begin
      pulse_d          = press_v;
      pulse_d[K_LEFT]  = press_v[K_LEFT]  | (lr_pulse & ~lr_sel_q);
      pulse_d[K_RIGHT] = press_v[K_RIGHT] | (lr_pulse &  lr_sel_q);
      pulse_d[K_DOWN]  = press_v[K_DOWN]  | dn_pulse;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_BASE;
         held_q   <= '0;
         pulse_q  <= '0;
         lr_sel_q <= 1'b0;
         lr_arr_q <= 1'b0;
         lr_cnt_q <= '0;
         dn_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         held_q   <= held_d;
         pulse_q  <= pulse_d;
         lr_sel_q <= lr_sel_d;
         lr_arr_q <= lr_arr_d;
         lr_cnt_q <= lr_cnt_d;
         dn_cnt_q <= dn_cnt_d;
      end
   end

   assign kev.key_left   = pulse_q[K_LEFT];
   assign kev.key_right  = pulse_q[K_RIGHT];
   assign kev.key_down   = pulse_q[K_DOWN];
   assign kev.key_rotate = pulse_q[K_ROTATE];
   assign kev.key_drop   = pulse_q[K_DROP];
   assign kev.keys_held  = held_q;
   assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_key_event_encoder.sv
// Directed bench for key_event_encoder: decoder vector table plus repeat-timing sequences.
module tb_key_event_encoder;

   logic       clk;
   logic       rst_n;
   logic [1:0] dbg_state;

   key_event_if kev();

   key_event_encoder dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .kev         (kev.master),
      .dbg_state_o (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [4:0] p_obs;
   logic [4:0] h_obs;
   logic [1:0] s_obs;

   localparam logic [4:0] P_L = 5'b00001;
   localparam logic [4:0] P_R = 5'b00010;
   localparam logic [4:0] P_D = 5'b00100;
   localparam logic [4:0] P_T = 5'b01000;
   localparam logic [4:0] P_X = 5'b10000;

   typedef struct {
      logic       tick;
      logic       vld;
      logic [7:0] code;
      logic [4:0] exp_p;
      logic [4:0] exp_h;
      logic [1:0] exp_s;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(logic t, logic v, logic [7:0] c,
                               logic [4:0] ep, logic [4:0] eh, logic [1:0] es);
      vec_t r;
      r.tick = t; r.vld = v; r.code = c; r.exp_p = ep; r.exp_h = eh; r.exp_s = es;
      tbl.push_back(r);
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // driver: apply one cycle of inputs, capture outputs 1 time unit after the edge
   task automatic step(input logic t, input logic v, input logic [7:0] c);
      kev.tick_game  = t;
      kev.scan_valid = v;
      kev.scan_code  = c;
      @(posedge clk);
      #1;
      p_obs = {kev.key_drop, kev.key_rotate, kev.key_down, kev.key_right, kev.key_left};
      h_obs = kev.keys_held;
      s_obs = dbg_state;
      kev.tick_game  = 1'b0;
      kev.scan_valid = 1'b0;
      kev.scan_code  = 8'h00;
   endtask

   task automatic byte_in(input logic [7:0] c);
      step(1'b0, 1'b1, c);
   endtask

   // tick followed by an idle cycle; returns the pulse vector seen after the tick
   // and checks the pulse does not persist into the idle cycle
   task automatic tick_once(input string name, output logic [4:0] seen);
      step(1'b1, 1'b0, 8'h00);
      seen = p_obs;
      step(1'b0, 1'b0, 8'h00);
      chk({name, "_pulse_width"}, {3'b0, p_obs}, 8'h00);
   endtask

   initial begin
      logic [4:0] seen;
      int n_l, n_r, n_d;
      kev.tick_game  = 1'b0;
      kev.scan_valid = 1'b0;
      kev.scan_code  = 8'h00;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_pulses", {3'b0, kev.key_drop, kev.key_rotate, kev.key_down,
                           kev.key_right, kev.key_left}, 8'h00);
      chk("reset_held", {3'b0, kev.keys_held}, 8'h00);
      chk("reset_state", {6'b0, dbg_state}, 8'h00);
      rst_n = 1'b1;

      // decoder table: {tick, valid, byte, expected pulses, expected held, expected state}
      add(0, 1, 8'hE0, 0,   0,       1);
      add(0, 1, 8'h6B, P_L, P_L,     0);
      add(0, 0, 8'h00, 0,   P_L,     0);
      add(0, 1, 8'hE0, 0,   P_L,     1);
      add(0, 1, 8'hF0, 0,   P_L,     3);
      add(0, 1, 8'h6B, 0,   0,       0);
      add(0, 1, 8'h29, P_X, P_X,     0);
      add(0, 1, 8'h29, 0,   P_X,     0);
      add(0, 1, 8'h29, 0,   P_X,     0);
      add(0, 1, 8'hF0, 0,   P_X,     2);
      add(0, 1, 8'h29, 0,   0,       0);
      add(0, 1, 8'h29, P_X, P_X,     0);
      add(0, 1, 8'hF0, 0,   P_X,     2);
      add(0, 1, 8'h29, 0,   0,       0);
      add(0, 1, 8'hFA, 0,   0,       0);
      add(0, 1, 8'hAA, 0,   0,       0);
      add(0, 1, 8'hEE, 0,   0,       0);
      add(0, 1, 8'hE0, 0,   0,       1);
      add(0, 1, 8'h75, P_T, P_T,     0);
      add(0, 1, 8'hE0, 0,   P_T,     1);
      add(0, 1, 8'h75, 0,   P_T,     0);
      add(0, 1, 8'hE0, 0,   P_T,     1);
      add(0, 1, 8'hF0, 0,   P_T,     3);
      add(0, 1, 8'h75, 0,   0,       0);
      add(0, 1, 8'hE0, 0,   0,       1);
      add(0, 1, 8'hE0, 0,   0,       1);
      add(0, 1, 8'h72, P_D, P_D,     0);
      add(0, 1, 8'hE0, 0,   P_D,     1);
      add(0, 1, 8'hF0, 0,   P_D,     3);
      add(0, 1, 8'h72, 0,   0,       0);
      add(0, 1, 8'hE0, 0,   0,       1);
      add(0, 1, 8'h12, 0,   0,       0);
      add(0, 1, 8'h6B, 0,   0,       0);
      add(0, 1, 8'hF0, 0,   0,       2);
      add(0, 1, 8'h6B, 0,   0,       0);
      add(1, 0, 8'h00, 0,   0,       0);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].tick, tbl[i].vld, tbl[i].code);
         chk($sformatf("vec%0d_pulses", i), {3'b0, p_obs}, {3'b0, tbl[i].exp_p});
         chk($sformatf("vec%0d_held", i),   {3'b0, h_obs}, {3'b0, tbl[i].exp_h});
         chk($sformatf("vec%0d_state", i),  {6'b0, s_obs}, {6'b0, tbl[i].exp_s});
      end

      // left DAS then ARR: pulses after ticks 10, 13, 16, 19
      byte_in(8'hE0);
      byte_in(8'h6B);
      chk("das_press", {3'b0, p_obs}, {3'b0, P_L});
      for (int t = 1; t <= 20; t++) begin
         tick_once("das", seen);
         chk($sformatf("das_tick%0d", t), {3'b0, seen},
             (t == 10 || t == 13 || t == 16 || t == 19) ? {3'b0, P_L} : 8'h00);
      end
      byte_in(8'hE0); byte_in(8'hF0); byte_in(8'h6B);
      chk("das_release_held", {3'b0, h_obs}, 8'h00);
      n_l = 0;
      for (int t = 0; t < 12; t++) begin
         tick_once("das_after", seen);
         if (seen != 0) n_l++;
      end
      chk("das_after_release", n_l[7:0], 8'd0);

      // soft drop: press pulse plus one every 2 ticks
      byte_in(8'hE0);
      byte_in(8'h72);
      n_d = (p_obs == P_D) ? 1 : 0;
      for (int t = 1; t <= 6; t++) begin
         tick_once("soft", seen);
         chk($sformatf("soft_tick%0d", t), {3'b0, seen}, (t % 2 == 0) ? {3'b0, P_D} : 8'h00);
         if (seen == P_D) n_d++;
      end
      chk("soft_total", n_d[7:0], 8'd4);
      byte_in(8'hE0); byte_in(8'hF0); byte_in(8'h72);

      // left then right: most recent repeats; releasing it restarts the other at DAS
      byte_in(8'hE0); byte_in(8'h6B);
      chk("lr_left_press", {3'b0, p_obs}, {3'b0, P_L});
      for (int t = 0; t < 5; t++) tick_once("lr_pre", seen);
      byte_in(8'hE0); byte_in(8'h74);
      chk("lr_right_press", {3'b0, p_obs}, {3'b0, P_R});
      chk("lr_both_held", {3'b0, h_obs}, {3'b0, P_L | P_R});
      n_l = 0; n_r = 0;
      for (int t = 1; t <= 10; t++) begin
         tick_once("lr_right", seen);
         if (seen[0]) n_l++;
         if (seen[1]) n_r++;
         if (t == 10) chk("lr_right_das", {3'b0, seen}, {3'b0, P_R});
      end
      chk("lr_left_silent", n_l[7:0], 8'd0);
      chk("lr_right_count", n_r[7:0], 8'd1);
      byte_in(8'hE0); byte_in(8'hF0); byte_in(8'h74);
      chk("lr_release_pulse", {3'b0, p_obs}, 8'h00);
      for (int t = 1; t <= 10; t++) begin
         tick_once("lr_left", seen);
         chk($sformatf("lr_left_tick%0d", t), {3'b0, seen}, (t == 10) ? {3'b0, P_L} : 8'h00);
      end
      byte_in(8'hE0); byte_in(8'hF0); byte_in(8'h6B);

      // make and tick in the same cycle: tick not counted, DAS still 10 more ticks
      byte_in(8'hE0);
      step(1'b1, 1'b1, 8'h6B);
      chk("mk_tick_press", {3'b0, p_obs}, {3'b0, P_L});
      for (int t = 1; t <= 10; t++) begin
         tick_once("mk_tick", seen);
         chk($sformatf("mk_tick%0d", t), {3'b0, seen}, (t == 10) ? {3'b0, P_L} : 8'h00);
      end
      byte_in(8'hE0); byte_in(8'hF0); byte_in(8'h6B);

      // reset mid-sequence discards the E0 prefix
      byte_in(8'hE0);
      rst_n = 1'b0;
      #2;
      chk("mid_reset_state", {6'b0, dbg_state}, 8'h00);
      chk("mid_reset_held", {3'b0, kev.keys_held}, 8'h00);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      byte_in(8'h6B);
      chk("post_reset_6b_pulse", {3'b0, p_obs}, 8'h00);
      chk("post_reset_6b_held", {3'b0, h_obs}, 8'h00);
      byte_in(8'h29);
      chk("drop_press2", {3'b0, p_obs}, {3'b0, P_X});
      byte_in(8'hE0); byte_in(8'hF0); byte_in(8'h29);
      chk("ext_brk_29_pulse", {3'b0, p_obs}, 8'h00);
      chk("ext_brk_29_held", {3'b0, h_obs}, {3'b0, P_X});
      byte_in(8'hF0); byte_in(8'h29);
      chk("drop_release", {3'b0, h_obs}, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
